// File: rtl/ula_arbiter.sv
// Round-robin arbiter sharing one combinational 16-bit ULA between two requesters.
// Optional grant counters are compiled in when ULA_ARB_STATS_EN is defined.
module ula_arbiter #(
  parameter int WIDTH = 16
`ifdef ULA_ARB_STATS_EN
  ,
  parameter int STAT_W = 16
`endif
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0Valid,
  output logic             req0Ready,
  input  logic [WIDTH-1:0] req0A,
  input  logic [WIDTH-1:0] req0B,
  input  logic [2:0]       req0Sel,
  input  logic             req1Valid,
  output logic             req1Ready,
  input  logic [WIDTH-1:0] req1A,
  input  logic [WIDTH-1:0] req1B,
  input  logic [2:0]       req1Sel,
  output logic [WIDTH-1:0] ulaA,
  output logic [WIDTH-1:0] ulaB,
  output logic [2:0]       ulaSelect,
  input  logic [WIDTH-1:0] ulaResult,
  input  logic             ulaCout,
  output logic             respValid,
  input  logic             respReady,
  output logic             respId,
  output logic [WIDTH-1:0] respResult,
  output logic             respCout
`ifdef ULA_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] grantCount0,
  output logic [STAT_W-1:0] grantCount1
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state_reg, state_next;
  logic             last_grant_reg;
  logic [WIDTH-1:0] ula_a_reg, ula_b_reg, resp_result_reg;
  logic [2:0]       ula_sel_reg;
  logic             resp_id_reg, resp_cout_reg;
  logic             grant0, grant1;
  logic [1:0]       grant_vec;

  // Grants are gated by reset so the ready outputs read 0 while reset is held.
  always_comb begin
    state_next = state_reg;
    grant0     = 1'b0;
    grant1     = 1'b0;
    case (state_reg)
      IDLE: begin
        grant0 = reset && req0Valid && (!req1Valid || last_grant_reg);
        grant1 = reset && req1Valid && (!req0Valid || !last_grant_reg);
        if (grant0 || grant1) state_next = EXEC;
      end
      EXEC:    state_next = RESP;
      RESP:    if (respReady) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg       <= IDLE;
      last_grant_reg  <= 1'b1;
      ula_a_reg       <= '0;
      ula_b_reg       <= '0;
      ula_sel_reg     <= '0;
      resp_id_reg     <= 1'b0;
      resp_result_reg <= '0;
      resp_cout_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (grant0 || grant1) begin
        ula_a_reg      <= grant1 ? req1A : req0A;
        ula_b_reg      <= grant1 ? req1B : req0B;
        ula_sel_reg    <= grant1 ? req1Sel : req0Sel;
        resp_id_reg    <= grant1;
        last_grant_reg <= grant1;
      end
      if (state_reg == EXEC) begin
        resp_result_reg <= ulaResult;
        resp_cout_reg   <= ulaCout;
      end
    end
  end

  assign grant_vec  = {grant1, grant0};
  assign req0Ready  = grant0;
  assign req1Ready  = grant1;
  assign ulaA       = ula_a_reg;
  assign ulaB       = ula_b_reg;
  assign ulaSelect  = ula_sel_reg;
  assign respValid  = (state_reg == RESP);
  assign respId     = resp_id_reg;
  assign respResult = resp_result_reg;
  assign respCout   = resp_cout_reg;

`ifdef ULA_ARB_STATS_EN
  // One saturating counter per requester, stepping on that requester's transfer.
  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
    logic [STAT_W-1:0] cnt_reg;
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) cnt_reg <= '0;
      else if (grant_vec[gi] && !(&cnt_reg)) cnt_reg <= cnt_reg + 1'b1;
    end
  end
  assign grantCount0 = g_cnt[0].cnt_reg;
  assign grantCount1 = g_cnt[1].cnt_reg;
`else
  logic unused_grant;
  assign unused_grant = ^grant_vec;
`endif

endmodule

// File: tb/tb_ula_arbiter.sv
// Self-checking bench for ula_arbiter with a behavioural ULA beside the DUT.
// Grant-counter checks are compiled in when ULA_ARB_STATS_EN is defined.
module tb_ula_arbiter;
  logic        clock, reset;
  logic        req0Valid, req0Ready, req1Valid, req1Ready;
  logic [15:0] req0A, req0B, req1A, req1B;
  logic [2:0]  req0Sel, req1Sel;
  logic [15:0] ulaA, ulaB, ulaResult, respResult;
  logic [2:0]  ulaSelect;
  logic        ulaCout, respValid, respReady, respId, respCout;
  int          errors = 0;
  int          checks = 0;

  // Behavioural ULA: returns {cout, result}.
  function automatic logic [16:0] ula_f(input logic [15:0] a, input logic [15:0] b,
                                        input logic [2:0] s);
    logic [16:0] sum, diff;
    sum  = {1'b0, a} + {1'b0, b};
    diff = {1'b0, a} + {1'b0, ~b} + 17'd1;
    case (s)
      3'd0:    return sum;
      3'd1:    return diff;
      3'd2:    return {1'b0, a & b};
      3'd3:    return {1'b0, a | b};
      3'd4:    return {1'b0, ~(a & b)};
      3'd5:    return {1'b0, ~(a | b)};
      3'd6:    return {1'b0, a ^ b};
      default: return {sum[16], 15'd0, ~sum[16]};
    endcase
  endfunction

  assign {ulaCout, ulaResult} = ula_f(ulaA, ulaB, ulaSelect);

`ifdef ULA_ARB_STATS_EN
  localparam int TB_STAT_W = 3;
  logic [TB_STAT_W-1:0] grantCount0, grantCount1;
  ula_arbiter #(.WIDTH(16), .STAT_W(TB_STAT_W)) dut (
    .clock(clock), .reset(reset),
    .req0Valid(req0Valid), .req0Ready(req0Ready), .req0A(req0A), .req0B(req0B), .req0Sel(req0Sel),
    .req1Valid(req1Valid), .req1Ready(req1Ready), .req1A(req1A), .req1B(req1B), .req1Sel(req1Sel),
    .ulaA(ulaA), .ulaB(ulaB), .ulaSelect(ulaSelect), .ulaResult(ulaResult), .ulaCout(ulaCout),
    .respValid(respValid), .respReady(respReady), .respId(respId),
    .respResult(respResult), .respCout(respCout),
    .grantCount0(grantCount0), .grantCount1(grantCount1));
`else
  ula_arbiter #(.WIDTH(16)) dut (
    .clock(clock), .reset(reset),
    .req0Valid(req0Valid), .req0Ready(req0Ready), .req0A(req0A), .req0B(req0B), .req0Sel(req0Sel),
    .req1Valid(req1Valid), .req1Ready(req1Ready), .req1A(req1A), .req1B(req1B), .req1Sel(req1Sel),
    .ulaA(ulaA), .ulaB(ulaB), .ulaSelect(ulaSelect), .ulaResult(ulaResult), .ulaCout(ulaCout),
    .respValid(respValid), .respReady(respReady), .respId(respId),
    .respResult(respResult), .respCout(respCout));
`endif

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Inputs change 1 time unit after a rising edge; checks follow 1 unit later.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    tick();
    reset = 1'b1;
  endtask

  task automatic issue_op(input bit id, input logic [15:0] a, input logic [15:0] b,
                          input logic [2:0] s);
    req0Valid = !id; req1Valid = id; respReady = 1'b1;
    if (id) begin req1A = a; req1B = b; req1Sel = s; end
    else    begin req0A = a; req0B = b; req0Sel = s; end
    tick();
    req0Valid = 1'b0; req1Valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0; req0Valid = 1'b1; req1Valid = 1'b1; respReady = 1'b1;
    req0A = 16'h1111; req0B = 16'h2222; req0Sel = 3'd0;
    req1A = 16'h3333; req1B = 16'h4444; req1Sel = 3'd1;
    #2;
    checks++;
    if ({req0Ready, req1Ready, respValid} !== 3'b000) begin
      errors++; $display("FAIL reset_ctrl: got %b want 000", {req0Ready, req1Ready, respValid});
    end
    checks++;
    if ({ulaA, ulaB, ulaSelect, respId, respResult, respCout} !== 54'd0) begin
      errors++; $display("FAIL reset_data: got %h want 0", {ulaA, ulaB, ulaSelect, respId, respResult, respCout});
    end
    tick();
    req0Valid = 1'b0; req1Valid = 1'b0;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    bit          ids[3]  = '{1'b0, 1'b1, 1'b0};
    logic [15:0] as[3]   = '{16'd10, 16'd10, 16'hFFFF};
    logic [15:0] bs[3]   = '{16'd5, 16'd5, 16'h0001};
    logic [2:0]  ss[3]   = '{3'd0, 3'd1, 3'd0};
    logic [15:0] er[3]   = '{16'd15, 16'd5, 16'h0000};
    bit          ec[3]   = '{1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 3; i++) begin
      req0Valid = !ids[i]; req1Valid = ids[i]; respReady = 1'b1;
      req0A = as[i]; req0B = bs[i]; req0Sel = ss[i];
      req1A = as[i]; req1B = bs[i]; req1Sel = ss[i];
      #1;
      checks++;
      if ({req1Ready, req0Ready} !== (ids[i] ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL basic_ready op%0d: got %b", i, {req1Ready, req0Ready});
      end
      tick();
      req0Valid = 1'b0; req1Valid = 1'b0;
      #1;
      checks++;
      if ({req1Ready, req0Ready, respValid} !== 3'b000 || {ulaA, ulaB, ulaSelect} !== {as[i], bs[i], ss[i]}) begin
        errors++; $display("FAIL basic_exec op%0d: ctrl %b ula %h/%h/%0d", i,
                           {req1Ready, req0Ready, respValid}, ulaA, ulaB, ulaSelect);
      end
      tick();
      #1;
      checks++;
      if ({respValid, respId, respResult, respCout} !== {1'b1, ids[i], er[i], ec[i]}) begin
        errors++; $display("FAIL basic_resp op%0d: got v=%b id=%b r=%h c=%b want v=1 id=%b r=%h c=%b",
                           i, respValid, respId, respResult, respCout, ids[i], er[i], ec[i]);
      end
      tick();
      #1;
      checks++;
      if (respValid !== 1'b0) begin
        errors++; $display("FAIL basic_drop op%0d: respValid %b want 0", i, respValid);
      end
    end
  endtask

  task automatic test_both_valid();
    logic [15:0] exp_r[2] = '{16'd123, 16'd42};
    do_reset();
    req0A = 16'd100; req0B = 16'd23; req0Sel = 3'd0;
    req1A = 16'd50;  req1B = 16'd8;  req1Sel = 3'd1;
    req0Valid = 1'b1; req1Valid = 1'b1; respReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if ({req1Ready, req0Ready} !== ((i % 2) ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL rr_grant op%0d: got %b", i, {req1Ready, req0Ready});
      end
      tick();
      tick();
      #1;
      checks++;
      if ({respValid, respId, respResult} !== {1'b1, 1'(i % 2), exp_r[i % 2]}) begin
        errors++; $display("FAIL rr_resp op%0d: got v=%b id=%b r=%0d want id=%0d r=%0d",
                           i, respValid, respId, respResult, i % 2, exp_r[i % 2]);
      end
      tick();
    end
    req0Valid = 1'b0; req1Valid = 1'b0;
  endtask

  task automatic test_back_to_back_hold();
    req0A = 16'd7; req0B = 16'd3; req0Sel = 3'd2;
    req0Valid = 1'b1; respReady = 1'b0;
    #1;
    checks++;
    if (req0Ready !== 1'b1) begin
      errors++; $display("FAIL hold_accept: req0Ready %b want 1", req0Ready);
    end
    tick();
    req0Valid = 1'b0;
    req1A = 16'h1234; req1B = 16'h00FF; req1Sel = 3'd6; req1Valid = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if ({respValid, respId, respResult, req0Ready, req1Ready} !== {1'b1, 1'b0, 16'd3, 2'b00}) begin
        errors++; $display("FAIL hold_stable cyc%0d: v=%b id=%b r=%h rdy=%b%b", k,
                           respValid, respId, respResult, req0Ready, req1Ready);
      end
      tick();
    end
    respReady = 1'b1;
    tick();
    #1;
    checks++;
    if ({respValid, req1Ready, req0Ready} !== 3'b010) begin
      errors++; $display("FAIL hold_next: got v=%b rdy1=%b rdy0=%b want 0 1 0", respValid, req1Ready, req0Ready);
    end
    tick();
    req1Valid = 1'b0;
    tick();
    #1;
    checks++;
    if ({respValid, respId, respResult} !== {1'b1, 1'b1, 16'h12CB}) begin
      errors++; $display("FAIL hold_resp2: got v=%b id=%b r=%h want 1 1 12cb", respValid, respId, respResult);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    req0A = 16'd1; req0B = 16'd2; req0Sel = 3'd0;
    req0Valid = 1'b1; req1Valid = 1'b0; respReady = 1'b1;
    tick();
    req1A = 16'd9; req1B = 16'd9; req1Sel = 3'd0; req1Valid = 1'b1;
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if ({req0Ready, req1Ready, respValid, ulaA, ulaB, ulaSelect, respId, respResult, respCout} !== 57'd0) begin
      errors++; $display("FAIL midreset_zero: rdy=%b%b v=%b ula=%h/%h", req0Ready, req1Ready, respValid, ulaA, ulaB);
    end
    tick();
    tick();
    #1;
    checks++;
    if (respValid !== 1'b0) begin
      errors++; $display("FAIL midreset_noresp: respValid %b want 0", respValid);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({req0Ready, req1Ready} !== 2'b10) begin
      errors++; $display("FAIL midreset_first: rdy0=%b rdy1=%b want 1 0", req0Ready, req1Ready);
    end
    tick();
    req0Valid = 1'b0; req1Valid = 1'b0;
    tick();
    #1;
    checks++;
    if ({respValid, respId, respResult} !== {1'b1, 1'b0, 16'd3}) begin
      errors++; $display("FAIL midreset_op: v=%b id=%b r=%0d want 1 0 3", respValid, respId, respResult);
    end
    tick();
  endtask

  task automatic test_random();
    bit          rv[2];
    bit          used[2];
    logic [15:0] ra[2], rb[2];
    logic [2:0]  rs[2];
    int          phase, w, pref;
    bit          m_last, m_id, m_cout;
    logic [15:0] m_res;
    logic [16:0] o;
    do_reset();
    phase = 0; m_last = 1'b1; m_id = 1'b0; m_res = '0; m_cout = 1'b0;
    for (int r = 0; r < 2; r++) begin rv[r] = 1'b0; used[r] = 1'b1; end
    for (int c = 0; c < 400; c++) begin
      for (int r = 0; r < 2; r++) begin
        if (used[r] || !rv[r] || $urandom_range(0, 7) == 0) begin
          rv[r] = 1'($urandom_range(0, 1));
          ra[r] = 16'($urandom); rb[r] = 16'($urandom); rs[r] = 3'($urandom_range(0, 7));
        end
        used[r] = 1'b0;
      end
      req0Valid = rv[0]; req0A = ra[0]; req0B = rb[0]; req0Sel = rs[0];
      req1Valid = rv[1]; req1A = ra[1]; req1B = rb[1]; req1Sel = rs[1];
      respReady = ($urandom_range(0, 3) != 0);
      #1;
      w = -1;
      if (phase == 0) begin
        pref = m_last ? 0 : 1;
        if (rv[pref]) w = pref;
        else if (rv[1 - pref]) w = 1 - pref;
      end
      checks++;
      if ({req0Ready, req1Ready} !== {w == 0, w == 1}) begin
        errors++; $display("FAIL rand_ready cyc%0d: got %b%b want %b%b", c, req0Ready, req1Ready, w == 0, w == 1);
      end
      checks++;
      if (respValid !== (phase == 2)) begin
        errors++; $display("FAIL rand_valid cyc%0d: got %b want %b", c, respValid, phase == 2);
      end
      if (phase == 2) begin
        checks++;
        if ({respId, respResult, respCout} !== {m_id, m_res, m_cout}) begin
          errors++; $display("FAIL rand_resp cyc%0d: got id=%b r=%h c=%b want id=%b r=%h c=%b",
                             c, respId, respResult, respCout, m_id, m_res, m_cout);
        end
      end
      if (w >= 0) begin
        o = ula_f(ra[w], rb[w], rs[w]);
        m_id = 1'(w); m_cout = o[16]; m_res = o[15:0];
        m_last = 1'(w); used[w] = 1'b1; phase = 1;
      end else if (phase == 1) phase = 2;
      else if (phase == 2 && respReady) phase = 0;
      tick();
    end
    req0Valid = 1'b0; req1Valid = 1'b0; respReady = 1'b1;
    tick(); tick(); tick();
  endtask

`ifdef ULA_ARB_STATS_EN
  task automatic test_stats();
    bit seq[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    do_reset();
    for (int i = 0; i < 5; i++) issue_op(seq[i], 16'(i), 16'd1, 3'd0);
    #1;
    checks++;
    if (grantCount0 !== 3'd3 || grantCount1 !== 3'd2) begin
      errors++; $display("FAIL stats_count: got %0d/%0d want 3/2", grantCount0, grantCount1);
    end
    for (int i = 0; i < 4; i++) issue_op(1'b0, 16'd1, 16'd1, 3'd0);
    #1;
    checks++;
    if (grantCount0 !== 3'd7) begin
      errors++; $display("FAIL stats_max: got %0d want 7", grantCount0);
    end
    for (int i = 0; i < 2; i++) issue_op(1'b0, 16'd1, 16'd1, 3'd0);
    #1;
    checks++;
    if (grantCount0 !== 3'd7 || grantCount1 !== 3'd2) begin
      errors++; $display("FAIL stats_sat: got %0d/%0d want 7/2", grantCount0, grantCount1);
    end
  endtask
`endif

  initial begin
    reset = 1'b0; respReady = 1'b0; req0Valid = 1'b0; req1Valid = 1'b0;
    test_reset();
    test_basic();
    test_both_valid();
    test_back_to_back_hold();
    test_reset_mid();
    test_random();
`ifdef ULA_ARB_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
